// File: rtl/poly_arith_pkg.sv
// Shared constants and types for the polynomial-arithmetic datapath.
// The tag id is sized for the largest supported requester count (8).
package poly_arith_pkg;

    localparam int WORD_W   = 64;
    localparam int TAG_ID_W = 3;

    localparam logic [WORD_W-1:0] Q_MOD = 64'd18434813901432784897;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } mul_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from last+1,
// pointer advances to the granted index on a completed handshake.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               hold,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic [ID_W-1:0] last_reg;
    logic [ID_W-1:0] idx;
    logic            found;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= ID_W'(NUM_REQ - 1);
        end else if (advance) begin
            last_reg <= grant_id;
        end
    end

    // Grants are suppressed while in reset so nothing is issued in that cycle.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_reg) + k) % NUM_REQ);
            if (!found && req[idx] && !hold && !rst) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_scheduler.sv
// Shares one pipelined modular multiplier among NUM_REQ requesters; a tag
// pipeline matched to the multiplier latency routes each product back.
module mul_scheduler
    import poly_arith_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 6,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*WORD_W-1:0] req_a,
    input  logic [NUM_REQ*WORD_W-1:0] req_b,
    input  logic                      hold,
    output logic [WORD_W-1:0]         mul_ina,
    output logic [WORD_W-1:0]         mul_inb,
    output logic                      mul_start,
    input  logic [WORD_W-1:0]         mul_out,
    input  logic                      mul_done,
    output logic                      res_valid,
    output logic [ID_W-1:0]           res_id,
    output logic [WORD_W-1:0]         res_data,
    output logic                      busy,
    output logic                      err_sync
);

    localparam int MASK_W = $clog2(MUL_LATENCY + 1);

    logic [NUM_REQ-1:0]     grant;
    logic [ID_W-1:0]        grant_id;
    logic                   handshake;

    logic [WORD_W-1:0]      mul_ina_reg;
    logic [WORD_W-1:0]      mul_inb_reg;
    logic                   mul_start_reg;
    logic [ID_W-1:0]        issue_id_reg;

    mul_tag_t               tag_reg [MUL_LATENCY];
    logic [MUL_LATENCY-1:0] tag_valid;
    mul_tag_t               last_tag;

    logic                   res_valid_reg;
    logic [ID_W-1:0]        res_id_reg;
    logic [WORD_W-1:0]      res_data_reg;
    logic                   err_sync_reg;
    logic [MASK_W-1:0]      mask_cnt_reg;

    assign req_ready = grant;
    assign handshake = |(req_valid & grant);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .hold     (hold),
        .advance  (handshake),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Operands hold their last value between issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_ina_reg   <= '0;
            mul_inb_reg   <= '0;
            mul_start_reg <= 1'b0;
            issue_id_reg  <= '0;
        end else begin
            mul_start_reg <= handshake;
            if (handshake) begin
                mul_ina_reg  <= req_a[int'(grant_id)*WORD_W +: WORD_W];
                mul_inb_reg  <= req_b[int'(grant_id)*WORD_W +: WORD_W];
                issue_id_reg <= grant_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_reg[0] <= '0;
        end else begin
            tag_reg[0] <= {mul_start_reg, TAG_ID_W'(issue_id_reg)};
        end
    end

    generate
        for (genvar gi = 1; gi < MUL_LATENCY; gi++) begin : g_tag_stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    tag_reg[gi] <= '0;
                end else begin
                    tag_reg[gi] <= tag_reg[gi-1];
                end
            end
        end
        for (genvar gi = 0; gi < MUL_LATENCY; gi++) begin : g_tag_valid
            assign tag_valid[gi] = tag_reg[gi].valid;
        end
    endgenerate

    assign last_tag = tag_reg[MUL_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_reg <= 1'b0;
            res_id_reg    <= '0;
            res_data_reg  <= '0;
        end else begin
            res_valid_reg <= last_tag.valid;
            if (last_tag.valid) begin
                res_id_reg   <= last_tag.id[ID_W-1:0];
                res_data_reg <= mul_out;
            end
        end
    end

    // The multiplier is not reset, so done pulses of dropped products may
    // still arrive for MUL_LATENCY cycles; the mask counter ignores them.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sync_reg <= 1'b0;
            mask_cnt_reg <= MASK_W'(MUL_LATENCY);
        end else begin
            if (mask_cnt_reg != '0) begin
                mask_cnt_reg <= mask_cnt_reg - 1'b1;
            end else if (mul_done != last_tag.valid) begin
                err_sync_reg <= 1'b1;
            end
        end
    end

    assign mul_ina   = mul_ina_reg;
    assign mul_inb   = mul_inb_reg;
    assign mul_start = mul_start_reg;
    assign res_valid = res_valid_reg;
    assign res_id    = res_id_reg;
    assign res_data  = res_data_reg;
    assign err_sync  = err_sync_reg;
    assign busy      = (|tag_valid) | mul_start_reg | res_valid_reg;

endmodule

// File: tb/tb_mul_scheduler.sv
// Directed bench for mul_scheduler with a behavioural modular multiplier
// whose latency can be lengthened to provoke a sync error.
module tb_mul_scheduler;
    import poly_arith_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int L       = 6;
    localparam int ID_W    = 2;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*WORD_W-1:0] req_a;
    logic [NUM_REQ*WORD_W-1:0] req_b;
    logic                      hold;
    logic [WORD_W-1:0]         mul_ina;
    logic [WORD_W-1:0]         mul_inb;
    logic                      mul_start;
    logic [WORD_W-1:0]         mul_out;
    logic                      mul_done;
    logic                      res_valid;
    logic [ID_W-1:0]           res_id;
    logic [WORD_W-1:0]         res_data;
    logic                      busy;
    logic                      err_sync;

    mul_scheduler #(.NUM_REQ(NUM_REQ), .MUL_LATENCY(L), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .hold(hold),
        .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_start(mul_start),
        .mul_out(mul_out), .mul_done(mul_done),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .busy(busy), .err_sync(err_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier, no reset, tap selects the latency.
    int          mdl_lat = L;
    logic        pv [0:7];
    logic [63:0] pd [0:7];

    function automatic logic [63:0] modmul(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        p = p % {64'd0, Q_MOD};
        return p[63:0];
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
    end

    always @(posedge clk) begin
        pv[0] <= mul_start;
        pd[0] <= modmul(mul_ina, mul_inb);
        for (int i = 1; i < 8; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    assign mul_done = pv[mdl_lat-1];
    assign mul_out  = pd[mdl_lat-1];

    // Event monitor, sampled on the falling edge.
    int          cyc = 0;
    int          hs_cyc[$];
    int          hs_id[$];
    int          st_cyc[$];
    int          rs_cyc[$];
    int          rs_id[$];
    logic [63:0] rs_data[$];
    int          exp_id[$];
    logic [63:0] exp_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                hs_cyc.push_back(cyc);
                hs_id.push_back(i);
            end
        end
        if (mul_start) st_cyc.push_back(cyc);
        if (res_valid) begin
            rs_cyc.push_back(cyc);
            rs_id.push_back(int'(res_id));
            rs_data.push_back(res_data);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        hs_cyc.delete(); hs_id.delete(); st_cyc.delete();
        rs_cyc.delete(); rs_id.delete(); rs_data.delete();
        exp_id.delete(); exp_data.delete();
    endtask

    task automatic set_lane(input int i, input logic [63:0] a, input logic [63:0] b);
        req_a[i*64 +: 64] = a;
        req_b[i*64 +: 64] = b;
    endtask

    // Compares recorded grants/starts/results against exp_id/exp_data.
    task automatic check_queue(input string tag, input bit consecutive);
        int n;
        n = exp_id.size();
        chk({tag, "_n_grant"}, hs_id.size(), n);
        chk({tag, "_n_start"}, st_cyc.size(), n);
        chk({tag, "_n_res"}, rs_id.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < hs_id.size() && i < st_cyc.size() && i < rs_id.size()) begin
                chk($sformatf("%s_grant%0d", tag, i), hs_id[i], exp_id[i]);
                chk($sformatf("%s_start_lat%0d", tag, i), st_cyc[i] - hs_cyc[i], 1);
                chk($sformatf("%s_res_lat%0d", tag, i), rs_cyc[i] - hs_cyc[i], L + 2);
                chk($sformatf("%s_res_id%0d", tag, i), rs_id[i], exp_id[i]);
                chk($sformatf("%s_res_data%0d", tag, i), rs_data[i], exp_data[i]);
                if (consecutive)
                    chk($sformatf("%s_b2b%0d", tag, i), hs_cyc[i] - hs_cyc[0], i);
            end
        end
    endtask

    initial begin
        logic [63:0] ea [4];
        logic [63:0] eb [4];
        logic [63:0] er [4];
        ea[0] = 64'd18434813901432784897; eb[0] = 64'd1;                    er[0] = 64'd0;
        ea[1] = 64'd18434813901432784898; eb[1] = 64'd1;                    er[1] = 64'd1;
        ea[2] = 64'd13901706437927406777; eb[2] = 64'd15700958295376441594; er[2] = 64'd2165091042952656860;
        ea[3] = 64'd1835666423505824111;  eb[3] = 64'd4408257175847215637;  er[3] = 64'd14699318972420960652;

        rst = 1'b1; hold = 1'b0; req_valid = '1; req_a = '0; req_b = '0;
        step();
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("rst_start", mul_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_err", err_sync, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ina", mul_ina, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_id", res_id, 0);
        step();
        rst = 1'b0;
        repeat (L + 2) step();

        // Fairness: all four valid for 12 cycles, pointer starts at 3.
        clear_q();
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, 64'(i + 1), 64'd10);
        req_valid = 4'b1111;
        repeat (12) step();
        req_valid = '0;
        repeat (L + 4) step();
        for (int k = 0; k < 12; k++) begin
            exp_id.push_back(k % 4);
            exp_data.push_back(64'((k % 4 + 1) * 10));
        end
        check_queue("fair", 1'b1);

        // Single request from requester 2.
        clear_q();
        set_lane(2, 64'd2, 64'd3);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("single_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        repeat (L + 4) step();
        exp_id.push_back(2); exp_data.push_back(64'd6);
        check_queue("single", 1'b0);

        // Modular edge cases, requester 0, back to back.
        clear_q();
        for (int k = 0; k < 4; k++) begin
            set_lane(0, ea[k], eb[k]);
            req_valid = 4'b0001;
            step();
            exp_id.push_back(0);
            exp_data.push_back(er[k]);
        end
        req_valid = '0;
        repeat (L + 4) step();
        check_queue("edge", 1'b1);

        // Hold: one product in flight, then 5 held cycles, then release.
        clear_q();
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, 64'(i + 1), 64'd7);
        req_valid = 4'b1111;
        step();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("hold_ready%0d", i), req_ready, 0);
            chk($sformatf("hold_busy%0d", i), busy, 1);
            step();
        end
        hold = 1'b0;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("hold_release_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        repeat (L + 4) step();
        exp_id.push_back(1); exp_data.push_back(64'd14);
        exp_id.push_back(2); exp_data.push_back(64'd21);
        check_queue("hold", 1'b0);
        @(negedge clk);
        chk("hold_drain_busy", busy, 0);
        step();

        // Reset while three products are in flight.
        clear_q();
        set_lane(0, 64'd5, 64'd5);
        req_valid = 4'b0001;
        repeat (3) step();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", req_ready, 0);
        step();
        rst = 1'b0;
        req_valid = '0;
        repeat (L + 4) step();
        @(negedge clk);
        chk("midrst_n_grant", hs_id.size(), 3);
        chk("midrst_n_res", rs_id.size(), 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err_sync, 0);
        step();

        // Sync fault: multiplier one cycle slower than the tag pipeline.
        clear_q();
        mdl_lat = L + 1;
        set_lane(3, 64'd3, 64'd3);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        repeat (L + 4) step();
        @(negedge clk);
        chk("sync_err", err_sync, 1);
        chk("sync_n_res", rs_id.size(), 1);
        if (rs_id.size() > 0) chk("sync_res_id", rs_id[0], 3);
        repeat (5) step();
        @(negedge clk);
        chk("sync_err_sticky", err_sync, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mdl_lat = L;
        @(negedge clk);
        chk("sync_err_cleared", err_sync, 0);
        repeat (L + 3) step();
        @(negedge clk);
        chk("sync_err_stays_clear", err_sync, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
